// File: rtl/adder_stream_reg.sv
// Registered stream adder: {co,s} = a + b + ci feeding a 2-entry skid FIFO with
// sticky carry flag and transfer counter. Define ADDER_STREAM_REG_OVF_CNT_EN for ovf_cnt.
module adder_stream_reg #(
  parameter int p_wordlength = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [p_wordlength-1:0] in_a,
  input  logic [p_wordlength-1:0] in_b,
  input  logic                    in_ci,
  input  logic                    in_vld,
  output logic                    in_rd,
  output logic [p_wordlength-1:0] out_s,
  output logic                    out_co,
  output logic                    out_vld,
  input  logic                    out_rd,
  output logic                    ovf_sticky,
  input  logic                    ovf_clr,
  output logic [7:0]              res_cnt
`ifdef ADDER_STREAM_REG_OVF_CNT_EN
  ,
  output logic [7:0]              ovf_cnt
`endif
);

  // Handshake: a transfer happens on a rising clk edge where valid=1 and ready=1
  // on the same interface; in_rd depends only on registered state.

  logic [p_wordlength:0] r_mem [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_occ;
  logic                  r_rdy;
  logic                  r_ovf_sticky;
  logic [7:0]            r_res_cnt;
  logic [p_wordlength:0] w_sum;
  logic                  w_push;
  logic                  w_pop;

  assign w_sum  = {1'b0, in_a} + {1'b0, in_b} + {{p_wordlength{1'b0}}, in_ci};

  // r_rdy keeps in_rd low during reset and for the cycle before the first edge.
  assign in_rd   = r_rdy & ~r_occ[1];
  assign out_vld = |r_occ;
  assign out_s   = r_mem[r_rd_ptr][p_wordlength-1:0];
  assign out_co  = r_mem[r_rd_ptr][p_wordlength];
  assign w_push  = in_vld & in_rd;
  assign w_pop   = out_vld & out_rd;

  assign ovf_sticky = r_ovf_sticky;
  assign res_cnt    = r_res_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0]  <= '0;
      r_mem[1]  <= '0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_occ     <= 2'd0;
      r_rdy     <= 1'b0;
    end else begin
      r_rdy <= 1'b1;
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_sum;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Set wins over clear when both happen in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_sticky <= 1'b0;
      r_res_cnt    <= 8'd0;
    end else begin
      if (w_push && w_sum[p_wordlength]) begin
        r_ovf_sticky <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf_sticky <= 1'b0;
      end
      if (w_pop) begin
        r_res_cnt <= r_res_cnt + 8'd1;
      end
    end
  end

`ifdef ADDER_STREAM_REG_OVF_CNT_EN
  logic [7:0] r_ovf_cnt;

  assign ovf_cnt = r_ovf_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_cnt <= 8'd0;
    end else if (w_push && w_sum[p_wordlength]) begin
      if (r_ovf_cnt != 8'hFF) begin
        r_ovf_cnt <= r_ovf_cnt + 8'd1;
      end
    end else if (ovf_clr) begin
      r_ovf_cnt <= 8'd0;
    end
  end
`endif

endmodule

// File: tb/tb_adder_stream_reg.sv
// Randomized bench for adder_stream_reg against a queue-based reference model.
// Define ADDER_STREAM_REG_OVF_CNT_EN to also exercise ovf_cnt.
module tb_adder_stream_reg;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_ci;
  logic         in_vld;
  logic         in_rd;
  logic [W-1:0] out_s;
  logic         out_co;
  logic         out_vld;
  logic         out_rd;
  logic         ovf_sticky;
  logic         ovf_clr;
  logic [7:0]   res_cnt;
`ifdef ADDER_STREAM_REG_OVF_CNT_EN
  logic [7:0]   ovf_cnt;
`endif

  adder_stream_reg #(.p_wordlength(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_ci      (in_ci),
    .in_vld     (in_vld),
    .in_rd      (in_rd),
    .out_s      (out_s),
    .out_co     (out_co),
    .out_vld    (out_vld),
    .out_rd     (out_rd),
    .ovf_sticky (ovf_sticky),
    .ovf_clr    (ovf_clr),
    .res_cnt    (res_cnt)
`ifdef ADDER_STREAM_REG_OVF_CNT_EN
    ,
    .ovf_cnt    (ovf_cnt)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [W:0] exp_q[$];
  int         m_res_cnt;
  bit         m_sticky;
  int         m_ovf_cnt;
  bit         m_up;
  int         n_checks;
  int         n_fail;
  int         n_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_res_cnt = 0;
    m_sticky  = 1'b0;
    m_ovf_cnt = 0;
    m_up      = 1'b0;
  endtask

  // One clock cycle: drive, check at negedge, advance model at posedge.
  task automatic drive_cycle(input bit vld, input int a, input int b, input bit ci,
                             input bit rd, input bit clr);
    bit exp_rdy;
    bit fire_in;
    bit fire_out;
    int sum;
    in_vld  = vld;
    in_a    = a[W-1:0];
    in_b    = b[W-1:0];
    in_ci   = ci;
    out_rd  = rd;
    ovf_clr = clr;
    @(negedge clk);
    exp_rdy = m_up && (exp_q.size() < 2);
    check("in_rd", in_rd, exp_rdy);
    check("out_vld", out_vld, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      check("out_s", out_s, exp_q[0][W-1:0]);
      check("out_co", out_co, exp_q[0][W]);
    end
    check("res_cnt", res_cnt, m_res_cnt);
    check("ovf_sticky", ovf_sticky, m_sticky);
`ifdef ADDER_STREAM_REG_OVF_CNT_EN
    check("ovf_cnt", ovf_cnt, m_ovf_cnt);
`endif
    if (out_vld && out_rd) n_out++;
    fire_in  = vld && exp_rdy;
    fire_out = rd && (exp_q.size() > 0);
    sum      = a + b + int'(ci);
    @(posedge clk);
    if (fire_out) begin
      void'(exp_q.pop_front());
      m_res_cnt = (m_res_cnt + 1) % 256;
    end
    if (fire_in) exp_q.push_back(sum[W:0]);
    if (fire_in && sum >= (1 << W)) begin
      m_sticky = 1'b1;
      if (m_ovf_cnt < 255) m_ovf_cnt++;
    end else if (clr) begin
      m_sticky  = 1'b0;
      m_ovf_cnt = 0;
    end
    m_up = 1'b1;
    #1;
  endtask

  task automatic rand_cycle(input bit vld, input bit rd, input bit clr);
    drive_cycle(vld, $urandom_range(0, (1 << W) - 1), $urandom_range(0, (1 << W) - 1),
                1'($urandom_range(0, 1)), rd, clr);
  endtask

  initial begin
    int r0;
    n_checks = 0;
    n_fail   = 0;
    n_out    = 0;
    model_reset();
    rst_n   = 1'b0;
    in_vld  = 1'b0;
    in_a    = '0;
    in_b    = '0;
    in_ci   = 1'b0;
    out_rd  = 1'b0;
    ovf_clr = 1'b0;

    #3;
    check("rst_out_vld", out_vld, 0);
    check("rst_in_rd", in_rd, 0);
    check("rst_out_s", out_s, 0);
    check("rst_out_co", out_co, 0);
    check("rst_res_cnt", res_cnt, 0);
    check("rst_sticky", ovf_sticky, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // in_rd must still be low until the first edge after release
    drive_cycle(0, 0, 0, 0, 1, 0);

    // 3 + 5 + 0
    drive_cycle(1, 3, 5, 0, 1, 0);
    drive_cycle(0, 0, 0, 0, 1, 0);
    check("s030_res_cnt", res_cnt, 1);

    // 15 + 15 + 1 sets sticky, then a clear pulse
    drive_cycle(1, 15, 15, 1, 1, 0);
    drive_cycle(0, 0, 0, 0, 1, 0);
    drive_cycle(0, 0, 0, 0, 1, 1);
    drive_cycle(0, 0, 0, 0, 1, 0);

    // Stall output: fills after two accepts, head holds, then drains in order
    drive_cycle(1, 1, 1, 0, 0, 0);
    drive_cycle(1, 2, 2, 0, 0, 0);
    drive_cycle(1, 3, 3, 0, 0, 0);
    drive_cycle(1, 3, 3, 0, 0, 0);
    check("s032_full_in_rd", in_rd, 0);
    check("s032_head", out_s, 2);
    drive_cycle(1, 3, 3, 0, 1, 0);
    drive_cycle(0, 0, 0, 0, 1, 0);
    drive_cycle(0, 0, 0, 0, 1, 0);
    drive_cycle(0, 0, 0, 0, 1, 0);

    // Set and clear in the same cycle: set wins
    drive_cycle(1, 15, 1, 0, 1, 1);
    drive_cycle(0, 0, 0, 0, 1, 0);

    // Continuous streaming of 100 operands
    r0    = m_res_cnt;
    n_out = 0;
    for (int i = 0; i < 100; i++) rand_cycle(1, 1, 0);
    drive_cycle(0, 0, 0, 0, 1, 0);
    check("s033_transfers", n_out, 100);
    check("s033_res_cnt", res_cnt, (r0 + 100) % 256);

    // Mixed random traffic, long enough to wrap res_cnt
    for (int i = 0; i < 600; i++)
      rand_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 7) == 0));

    // Asynchronous reset with the FIFO full
    drive_cycle(0, 0, 0, 0, 1, 0);
    drive_cycle(0, 0, 0, 0, 1, 0);
    drive_cycle(1, 7, 8, 1, 0, 0);
    drive_cycle(1, 9, 9, 0, 0, 0);
    check("s034_pre_full", in_rd, 0);
    #2 rst_n = 1'b0;
    #1;
    check("s034_out_vld", out_vld, 0);
    check("s034_in_rd", in_rd, 0);
    check("s034_out_s", out_s, 0);
    check("s034_res_cnt", res_cnt, 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) drive_cycle(0, 0, 0, 0, 1, 0);
    check("s034_no_stale", n_out >= 0 && !out_vld, 1);

`ifdef ADDER_STREAM_REG_OVF_CNT_EN
    // 300 accepted inputs with carry out: counter saturates
    for (int i = 0; i < 300; i++) drive_cycle(1, 15, 15, 1, 1, 0);
    drive_cycle(0, 0, 0, 0, 1, 0);
    check("s035_ovf_cnt", ovf_cnt, 255);
    drive_cycle(0, 0, 0, 0, 1, 1);
    drive_cycle(0, 0, 0, 0, 1, 0);
`endif

    for (int i = 0; i < 50; i++) rand_cycle(1, 1'($urandom_range(0, 1)), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
